lcd_bus_responder: RTL and testbench
====================================

LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 The block SHALL have parameter BUSY_CYC, default 40, meaning busy cycles after a normal command or data write.
REQ-002 The block SHALL have parameter BUSY_LONG, default 1520, meaning busy cycles after Return Home.
REQ-003 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- lcd_e  in  1  host enable strobe.
- lcd_rs  in  1  0 = instruction, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_data_in  in  8  host bus.
- lcd_data_out  out  8  read-back bus.
- lcd_data_oe  out  1  read-back drive enable.
- scan_addr  in  7  display-scan DDRAM read address.
- scan_data  out  8  DDRAM[scan_addr], registered, 1-cycle latency.
- cursor_addr  out  7  address counter (AC).
- shift_ofs  out  6  display shift offset, 0..39.
- disp_on, cursor_on, blink_on, line2, bus8  out  1 each  current mode bits.
- busy  out  1  busy flag.
- cmd_strobe  out  1  1-cycle pulse per accepted transfer.
- overrun  out  1  1-cycle pulse on a write dropped while busy.
- err  out  1  1-cycle pulse on an illegal address or a disabled command.

Function
REQ-004 The block SHALL pass lcd_e through a 2-flop synchronizer; the block SHALL register lcd_rs, lcd_rw and lcd_data_in every cycle in which synchronized E is high; a transfer SHALL occur on the synchronized falling edge using those captured values.
REQ-005 Register effects of a transfer SHALL be visible 1 cycle after the falling-edge detect cycle; cmd_strobe SHALL pulse in that same cycle.
REQ-006 A write (rw=0) arriving while busy=1 SHALL be dropped with no state change; overrun SHALL pulse.
REQ-007 Reads SHALL be accepted at any time; lcd_data_oe SHALL be 1 while synchronized E=1 and captured rw=1; rs=0 SHALL drive {busy, AC}, and rs=1 SHALL drive DDRAM[AC].
REQ-008 A data read SHALL step AC per I/D.
REQ-009 Instructions SHALL decode by the highest set bit:
- 0x01 Clear: fill DDRAM with 0x20 at 1 byte per cycle (80 cycles); AC=0; shift_ofs=0; I/D=1.
- 0x02/0x03 Home: AC=0; shift_ofs=0.
- 0b000001[I/D][S] Entry mode.
- 0b00001[D][C][B] Display control.
- 0b0001[S/C][R/L]xx Shift: S/C=0 steps AC by ±1 with wrap; S/C=1 steps shift_ofs by ±1 mod 40.
- 0b001[DL][N]xx Function set: bus8=DL, line2=N.
- 0b01xxxxxx Set CGRAM address (see Configuration).
- 0b1aaaaaaa Set DDRAM address.
REQ-010 A data write (rs=1, rw=0) SHALL store the byte at DDRAM[AC], step AC per I/D, and, if S=1, step shift_ofs in the same direction.
REQ-011 Valid DDRAM addresses SHALL be 0x00-0x27 and 0x40-0x67 when line2=1, and 0x00-0x4F when line2=0; Set DDRAM to an invalid address SHALL be ignored and err SHALL pulse.
REQ-012 AC wrap for line2=1 SHALL be: increment 0x27->0x40 and 0x67->0x00; decrement 0x00->0x67 and 0x40->0x27.
REQ-013 AC wrap for line2=0 SHALL be: 0x4F->0x00 and 0x00->0x4F.
REQ-014 busy SHALL assert in the cycle effects apply and stay asserted for: BUSY_CYC cycles for normal writes; 80+BUSY_CYC cycles for Clear; BUSY_LONG cycles for Home.
REQ-015 Reads SHALL NOT set busy.
REQ-016 A scan read colliding with a Clear fill or data write to the same address SHALL return the old value.

Reset
REQ-017 On rst, the block SHALL set AC=0, shift_ofs=0, disp_on=0, cursor_on=0, blink_on=0, line2=0, bus8=1, I/D=1, S=0, busy=0, lcd_data_oe=0, lcd_data_out=0, and all pulses=0.
REQ-018 On rst, synchronizers SHALL clear and any Clear fill in progress SHALL abort.
REQ-019 DDRAM contents SHALL NOT be reset.

Configuration
REQ-020 Macro LCD_CGRAM_EN SHALL control CGRAM support.
REQ-021 With LCD_CGRAM_EN defined:
- A 64x8 CGRAM SHALL be added.
- Set CGRAM SHALL load a 6-bit CG address and select CGRAM as the data target.
- Data writes and reads SHALL target CGRAM with a mod-64 address step until the next Set DDRAM or Clear.
- Read of {busy, AC} SHALL report the CG address.
REQ-022 Without LCD_CGRAM_EN, Set CGRAM SHALL be ignored and err SHALL pulse.

Verification
REQ-023 Init sequence: host sends 0x3C, 0x0C, 0x01, 0x06, each after busy clears -> line2=1, bus8=1, disp_on=1, cursor_on=0; DDRAM all 0x20; AC=0; I/D=1.
REQ-024 Wrap: line2=1, Set DDRAM 0x27, write 'A' -> DDRAM[0x27]=0x41, AC=0x40; Entry 0x04 then Shift 0x10 at AC=0x00 -> AC=0x67.
REQ-025 Busy: write 0x41 then write 0x42 five cycles later -> second write dropped, overrun pulses once, busy stays high for exactly BUSY_CYC cycles.
REQ-026 Read-back: AC=0x05 with busy=1, read rs=0 -> lcd_data_out=0x85 with lcd_data_oe=1; after busy clears, read rs=1 -> byte at 0x05, AC=0x06.
REQ-027 Reset mid-Clear: assert rst 20 cycles into the fill -> busy=0, AC=0, all mode bits at reset values on the next cycle.
REQ-028 Config: send 0x48 -> err pulses without LCD_CGRAM_EN; with LCD_CGRAM_EN, a following data write 0x1F lands at CGRAM[0x08] and the CG address becomes 0x09.

Source files
------------

// File: rtl/lcd_bus_responder_if.sv
// Host-side parallel LCD bus (HD44780-style) shared by the host model
// and the bus responder. The host owns the strobe, the control lines and
// the write bus; the responder owns the read-back bus and its drive enable.
interface lcd_bus_responder_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data_in;
    logic [7:0] lcd_data_out;
    logic       lcd_data_oe;

    modport master (
        output lcd_e, lcd_rs, lcd_rw, lcd_data_in,
        input  lcd_data_out, lcd_data_oe
    );

    modport slave (
        input  lcd_e, lcd_rs, lcd_rw, lcd_data_in,
        output lcd_data_out, lcd_data_oe
    );
endinterface

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: emulates the controller side of an HD44780-style
// character LCD. Host transfers complete on the synchronized falling edge
// of E; instructions update the address counter, display shift and mode
// bits, data writes land in a 128x8 DDRAM that a display scanner reads
// through a separate registered port.
// Optional feature: define LCD_CGRAM_EN to add a 64x8 CGRAM selected by
// Set CGRAM address; without it Set CGRAM is rejected with err.
module lcd_bus_responder #(
    parameter int BUSY_CYC  = 40,
    parameter int BUSY_LONG = 1520
) (
    input  logic               clk,
    input  logic               rst,
    lcd_bus_responder_if.slave bus,
    input  logic [6:0]         scan_addr,
    output logic [7:0]         scan_data,
    output logic [6:0]         cursor_addr,
    output logic [5:0]         shift_ofs,
    output logic               disp_on,
    output logic               cursor_on,
    output logic               blink_on,
    output logic               line2,
    output logic               bus8,
    output logic               busy,
    output logic               cmd_strobe,
    output logic               overrun,
    output logic               err
);

    localparam int MAX_BUSY = (BUSY_LONG > BUSY_CYC) ? BUSY_LONG : BUSY_CYC;
    localparam int CNT_W    = $clog2(MAX_BUSY + 1);
    localparam logic [CNT_W-1:0] CYC_LOAD  = CNT_W'(BUSY_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD = CNT_W'(BUSY_LONG - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_WAIT} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] busy_cnt;
    logic [6:0]       fill_idx;
    logic [6:0]       fill_addr;
    logic             fill_we;

    logic             e_meta;
    logic             e_sync;
    logic             e_prev;
    logic             cap_rs;
    logic             cap_rw;
    logic [7:0]       cap_data;

    logic             fall;
    logic             wr_accept;
    logic             wr_drop;
    logic             rd_accept;
    logic             is_clear;
    logic             is_home;

    logic [6:0]       ac;
    logic             inc_dec;
    logic             disp_shift;
    logic             cg_sel;

    logic [7:0]       ddram [0:127];
    logic             mem_we;
    logic [6:0]       mem_wa;
    logic [7:0]       mem_wd;
    logic [7:0]       data_byte;
    logic [7:0]       status_byte;

    // Address counter step with the line-aware wrap points
    function automatic logic [6:0] step_ac(input logic [6:0] a, input logic inc, input logic l2);
        logic [6:0] r;
        if (l2) begin
            if (inc) r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
            else     r = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
        end else begin
            if (inc) r = (a == 7'h4F) ? 7'h00 : a + 7'd1;
            else     r = (a == 7'h00) ? 7'h4F : a - 7'd1;
        end
        return r;
    endfunction

    // Display shift offset steps modulo the 40-column line length
    function automatic logic [5:0] step_ofs(input logic [5:0] o, input logic inc);
        if (inc) return (o == 6'd39) ? 6'd0 : o + 6'd1;
        else     return (o == 6'd0) ? 6'd39 : o - 6'd1;
    endfunction

    function automatic logic ddram_valid(input logic [6:0] a, input logic l2);
        if (l2) return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
        else    return (a <= 7'h4F);
    endfunction

    // Bring the asynchronous host strobe into the clock domain and keep
    // one extra stage so its falling edge can be detected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_meta <= 1'b0;
            e_sync <= 1'b0;
            e_prev <= 1'b0;
        end else begin
            e_meta <= bus.lcd_e;
            e_sync <= e_meta;
            e_prev <= e_sync;
        end
    end

    // Hold the last control/data values seen while E was high; the
    // transfer on the falling edge uses these
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_rs   <= 1'b0;
            cap_rw   <= 1'b0;
            cap_data <= 8'h00;
        end else if (e_sync) begin
            cap_rs   <= bus.lcd_rs;
            cap_rw   <= bus.lcd_rw;
            cap_data <= bus.lcd_data_in;
        end
    end

    assign fall      = e_prev & ~e_sync;
    assign wr_accept = fall & ~cap_rw & ~busy;
    assign wr_drop   = fall & ~cap_rw & busy;
    assign rd_accept = fall & cap_rw;
    assign is_clear  = ~cap_rs & (cap_data == 8'h01);
    assign is_home   = ~cap_rs & (cap_data[7:1] == 7'b0000001);

    // Busy sequencer state register; reset aborts any fill in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Busy sequencer transitions: Clear fills first, everything else waits
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (wr_accept) state_nxt = is_clear ? ST_FILL : ST_WAIT;
            ST_FILL: if (fill_idx == 7'd79) state_nxt = ST_WAIT;
            ST_WAIT: if (busy_cnt == '0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Busy flag and fill write enable follow directly from the state
    always_comb begin
        busy    = (state != ST_IDLE);
        fill_we = (state == ST_FILL);
    end

    // Fill index and busy countdown; the count is reloaded while filling so
    // the post-fill wait always starts from the normal busy length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_cnt <= '0;
            fill_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: if (wr_accept) begin
                    fill_idx <= '0;
                    busy_cnt <= is_home ? LONG_LOAD : CYC_LOAD;
                end
                ST_FILL: begin
                    fill_idx <= fill_idx + 7'd1;
                    busy_cnt <= CYC_LOAD;
                end
                ST_WAIT: busy_cnt <= busy_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign fill_addr = (line2 && (fill_idx >= 7'd40)) ? fill_idx + 7'd24 : fill_idx;

    // Address counter, shift offset, mode bits and event pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac         <= 7'h00;
            shift_ofs  <= 6'd0;
            disp_on    <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            line2      <= 1'b0;
            bus8       <= 1'b1;
            inc_dec    <= 1'b1;
            disp_shift <= 1'b0;
            cmd_strobe <= 1'b0;
            overrun    <= 1'b0;
            err        <= 1'b0;
        end else begin
            cmd_strobe <= wr_accept | rd_accept;
            overrun    <= wr_drop;
            err        <= 1'b0;
            if (rd_accept && cap_rs && !cg_sel) ac <= step_ac(ac, inc_dec, line2);
            if (wr_accept) begin
                if (cap_rs) begin
                    if (!cg_sel) begin
                        ac <= step_ac(ac, inc_dec, line2);
                        if (disp_shift) shift_ofs <= step_ofs(shift_ofs, inc_dec);
                    end
                end else begin
                    casez (cap_data)
                        8'b1???????: begin
                            if (ddram_valid(cap_data[6:0], line2)) ac <= cap_data[6:0];
                            else err <= 1'b1;
                        end
                        8'b01??????: begin
`ifdef LCD_CGRAM_EN
`else
                            err <= 1'b1;
`endif
                        end
                        8'b001?????: begin
                            bus8  <= cap_data[4];
                            line2 <= cap_data[3];
                        end
                        8'b0001????: begin
                            if (cap_data[3]) shift_ofs <= step_ofs(shift_ofs, cap_data[2]);
                            else ac <= step_ac(ac, cap_data[2], line2);
                        end
                        8'b00001???: begin
                            disp_on   <= cap_data[2];
                            cursor_on <= cap_data[1];
                            blink_on  <= cap_data[0];
                        end
                        8'b000001??: begin
                            inc_dec    <= cap_data[1];
                            disp_shift <= cap_data[0];
                        end
                        8'b0000001?: begin
                            ac        <= 7'h00;
                            shift_ofs <= 6'd0;
                        end
                        8'b00000001: begin
                            ac        <= 7'h00;
                            shift_ofs <= 6'd0;
                            inc_dec   <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef LCD_CGRAM_EN
    logic [7:0] cgram [0:63];
    logic [5:0] cg_addr;

    // CGRAM target select and its 6-bit address, which wraps modulo 64
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cg_sel  <= 1'b0;
            cg_addr <= 6'd0;
        end else if (wr_accept && !cap_rs) begin
            if (cap_data[7] && ddram_valid(cap_data[6:0], line2)) begin
                cg_sel <= 1'b0;
            end else if (cap_data[7:6] == 2'b01) begin
                cg_sel  <= 1'b1;
                cg_addr <= cap_data[5:0];
            end else if (cap_data == 8'h01) begin
                cg_sel <= 1'b0;
            end
        end else if ((wr_accept || rd_accept) && cap_rs && cg_sel) begin
            cg_addr <= inc_dec ? cg_addr + 6'd1 : cg_addr - 6'd1;
        end
    end

    // CGRAM storage, written by data writes while CGRAM is selected
    always_ff @(posedge clk) begin
        if (wr_accept && cap_rs && cg_sel) cgram[cg_addr] <= cap_data;
    end

    assign data_byte   = cg_sel ? cgram[cg_addr] : ddram[ac];
    assign status_byte = cg_sel ? {busy, 1'b0, cg_addr} : {busy, ac};
`else
    assign cg_sel      = 1'b0;
    assign data_byte   = ddram[ac];
    assign status_byte = {busy, ac};
`endif

    assign mem_we = fill_we | (wr_accept & cap_rs & ~cg_sel);
    assign mem_wa = fill_we ? fill_addr : ac;
    assign mem_wd = fill_we ? 8'h20 : cap_data;

    // DDRAM write port and registered scan port; a scan of the address being
    // written returns the previous contents
    always_ff @(posedge clk) begin
        if (mem_we) ddram[mem_wa] <= mem_wd;
        scan_data <= ddram[scan_addr];
    end

    assign cursor_addr      = ac;
    assign bus.lcd_data_oe  = e_sync & cap_rw;
    assign bus.lcd_data_out = bus.lcd_data_oe ? (cap_rs ? data_byte : status_byte) : 8'h00;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed self-checking bench for lcd_bus_responder: init sequence, AC
// wrap, busy/overrun, read-back, Home, entry shift, single-line mode,
// Set CGRAM handling (both LCD_CGRAM_EN builds) and reset during Clear.
module tb_lcd_bus_responder;

    localparam int BUSY_CYC  = 40;
    localparam int BUSY_LONG = 1520;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] scan_addr;
    logic [7:0] scan_data;
    logic [6:0] cursor_addr;
    logic [5:0] shift_ofs;
    logic       disp_on, cursor_on, blink_on, line2, bus8;
    logic       busy, cmd_strobe, overrun, err;

    int n_checks  = 0;
    int n_fail    = 0;
    int run_cnt   = 0;
    int last_run  = 0;
    int ovr_total = 0;
    int ovr_before;

    logic [7:0] t_rdata;
    logic       t_oe, t_strobe, t_ovr, t_err;

    lcd_bus_responder_if bus_if ();

    lcd_bus_responder #(.BUSY_CYC(BUSY_CYC), .BUSY_LONG(BUSY_LONG)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus_if),
        .scan_addr   (scan_addr),
        .scan_data   (scan_data),
        .cursor_addr (cursor_addr),
        .shift_ofs   (shift_ofs),
        .disp_on     (disp_on),
        .cursor_on   (cursor_on),
        .blink_on    (blink_on),
        .line2       (line2),
        .bus8        (bus8),
        .busy        (busy),
        .cmd_strobe  (cmd_strobe),
        .overrun     (overrun),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Length of the most recent busy run and a running overrun count
    always @(negedge clk) begin
        if (busy === 1'b1) run_cnt++;
        else begin
            if (run_cnt != 0) last_run = run_cnt;
            run_cnt = 0;
        end
        if (overrun === 1'b1) ovr_total++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete host transfer; the read bus is sampled late in the E-high
    // window and the pulses in the cycle the transfer takes effect
    task automatic applyStimulus(input logic rs, input logic rw, input logic [7:0] d);
        @(negedge clk);
        bus_if.lcd_rs      = rs;
        bus_if.lcd_rw      = rw;
        bus_if.lcd_data_in = d;
        bus_if.lcd_e       = 1'b1;
        repeat (4) @(negedge clk);
        t_rdata = bus_if.lcd_data_out;
        t_oe    = bus_if.lcd_data_oe;
        bus_if.lcd_e = 1'b0;
        repeat (3) @(negedge clk);
        t_strobe = cmd_strobe;
        t_ovr    = overrun;
        t_err    = err;
    endtask

    task automatic waitReady();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) checkOutput("ready_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic sendCmd(input logic [7:0] d);
        applyStimulus(1'b0, 1'b0, d);
        waitReady();
    endtask

    task automatic scanCheck(input string tag, input logic [6:0] a, input logic [7:0] exp);
        @(negedge clk);
        scan_addr = a;
        @(negedge clk);
        checkOutput(tag, scan_data, exp);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus_if.lcd_e = 1'b0;
        bus_if.lcd_rs = 1'b0;
        bus_if.lcd_rw = 1'b0;
        bus_if.lcd_data_in = 8'h00;
        scan_addr = 7'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        checkOutput("rst_ac", cursor_addr, 7'h00);
        checkOutput("rst_shift", shift_ofs, 6'd0);
        checkOutput("rst_modes", {disp_on, cursor_on, blink_on, line2, bus8}, 5'b00001);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_oe", bus_if.lcd_data_oe, 1'b0);
        checkOutput("rst_dout", bus_if.lcd_data_out, 8'h00);
        checkOutput("rst_pulses", {cmd_strobe, overrun, err}, 3'b000);

        // Init sequence
        applyStimulus(1'b0, 1'b0, 8'h3C);
        checkOutput("fs_strobe", t_strobe, 1'b1);
        checkOutput("fs_busy", busy, 1'b1);
        waitReady();
        checkOutput("fs_line2_bus8", {line2, bus8}, 2'b11);
        sendCmd(8'h0C);
        checkOutput("dc_modes", {disp_on, cursor_on, blink_on}, 3'b100);
        sendCmd(8'h01);
        checkOutput("clr_busy_len", last_run, 80 + BUSY_CYC);
        sendCmd(8'h06);
        checkOutput("init_ac", cursor_addr, 7'h00);
        scanCheck("clr_00", 7'h00, 8'h20);
        scanCheck("clr_27", 7'h27, 8'h20);
        scanCheck("clr_40", 7'h40, 8'h20);
        scanCheck("clr_67", 7'h67, 8'h20);

        // Two-line AC wrap
        sendCmd(8'hA7);
        applyStimulus(1'b1, 1'b0, 8'h41);
        waitReady();
        checkOutput("wrap_inc_ac", cursor_addr, 7'h40);
        scanCheck("wrap_mem27", 7'h27, 8'h41);
        sendCmd(8'h80);
        sendCmd(8'h04);
        sendCmd(8'h10);
        checkOutput("wrap_dec_ac", cursor_addr, 7'h67);
        applyStimulus(1'b0, 1'b0, 8'hA8);
        checkOutput("bad_ddram_err", t_err, 1'b1);
        waitReady();
        checkOutput("bad_ddram_ac", cursor_addr, 7'h67);
        sendCmd(8'h06);

        // Display shift wraps modulo 40
        sendCmd(8'h18);
        checkOutput("shift_left", shift_ofs, 6'd39);
        sendCmd(8'h1C);
        checkOutput("shift_right", shift_ofs, 6'd0);

        // Write dropped while busy
        sendCmd(8'h90);
        ovr_before = ovr_total;
        applyStimulus(1'b1, 1'b0, 8'h41);
        checkOutput("busy_w1_strobe", t_strobe, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h42);
        checkOutput("busy_w2_ovr", t_ovr, 1'b1);
        checkOutput("busy_w2_strobe", t_strobe, 1'b0);
        waitReady();
        checkOutput("busy_len", last_run, BUSY_CYC);
        checkOutput("busy_ovr_count", ovr_total - ovr_before, 1);
        checkOutput("busy_ac", cursor_addr, 7'h11);
        scanCheck("busy_mem10", 7'h10, 8'h41);
        scanCheck("busy_mem11", 7'h11, 8'h20);

        // Read-back of status and data
        sendCmd(8'h85);
        applyStimulus(1'b1, 1'b0, 8'h5A);
        waitReady();
        applyStimulus(1'b0, 1'b0, 8'h85);
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("rd_status", t_rdata, 8'h85);
        checkOutput("rd_status_oe", t_oe, 1'b1);
        checkOutput("rd_strobe", t_strobe, 1'b1);
        waitReady();
        applyStimulus(1'b1, 1'b1, 8'h00);
        checkOutput("rd_data", t_rdata, 8'h5A);
        checkOutput("rd_data_oe", t_oe, 1'b1);
        checkOutput("rd_ac_step", cursor_addr, 7'h06);
        checkOutput("rd_no_busy", busy, 1'b0);

        // Return Home
        sendCmd(8'h1C);
        sendCmd(8'h02);
        checkOutput("home_ac", cursor_addr, 7'h00);
        checkOutput("home_shift", shift_ofs, 6'd0);
        checkOutput("home_busy_len", last_run, BUSY_LONG);

        // Entry mode with display shift on data write
        sendCmd(8'h07);
        applyStimulus(1'b1, 1'b0, 8'h33);
        waitReady();
        checkOutput("es_ac", cursor_addr, 7'h01);
        checkOutput("es_shift", shift_ofs, 6'd1);
        scanCheck("es_mem00", 7'h00, 8'h33);
        sendCmd(8'h06);

        // Single-line mode
        sendCmd(8'h30);
        checkOutput("l1_modes", {line2, bus8}, 2'b01);
        sendCmd(8'hCF);
        checkOutput("l1_set4f", cursor_addr, 7'h4F);
        applyStimulus(1'b1, 1'b0, 8'h44);
        waitReady();
        checkOutput("l1_wrap", cursor_addr, 7'h00);
        applyStimulus(1'b0, 1'b0, 8'hD0);
        checkOutput("l1_bad_err", t_err, 1'b1);
        waitReady();
        sendCmd(8'h20);
        checkOutput("bus4", bus8, 1'b0);

        // Set CGRAM address
`ifdef LCD_CGRAM_EN
        applyStimulus(1'b0, 1'b0, 8'h48);
        checkOutput("cg_no_err", t_err, 1'b0);
        waitReady();
        applyStimulus(1'b1, 1'b0, 8'h1F);
        waitReady();
        applyStimulus(1'b0, 1'b1, 8'h00);
        checkOutput("cg_addr", t_rdata, 8'h09);
        sendCmd(8'h48);
        applyStimulus(1'b1, 1'b1, 8'h00);
        checkOutput("cg_data", t_rdata, 8'h1F);
        sendCmd(8'h80);
`else
        applyStimulus(1'b0, 1'b0, 8'h48);
        checkOutput("cg_err", t_err, 1'b1);
        checkOutput("cg_strobe", t_strobe, 1'b1);
        waitReady();
        checkOutput("cg_ac_kept", cursor_addr, 7'h00);
`endif

        // Reset during Clear fill
        sendCmd(8'h3C);
        sendCmd(8'h0C);
        applyStimulus(1'b0, 1'b0, 8'h01);
        repeat (20) @(negedge clk);
        checkOutput("mid_clr_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_busy", busy, 1'b0);
        checkOutput("mid_rst_ac", cursor_addr, 7'h00);
        checkOutput("mid_rst_modes", {disp_on, cursor_on, blink_on, line2, bus8}, 5'b00001);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_idle", busy, 1'b0);
        scanCheck("mid_rst_mem27", 7'h27, 8'h41);
        applyStimulus(1'b0, 1'b0, 8'h0F);
        checkOutput("post_rst_strobe", t_strobe, 1'b1);
        waitReady();
        checkOutput("post_rst_modes", {disp_on, cursor_on, blink_on}, 3'b111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
